// File: rtl/audio_feeder_pkg.sv
// Shared types and widths for the audio output feeder: FSM encoding, sample and counter widths.
package audio_feeder_pkg;

  localparam int SAMPLE_W = 32;
  localparam int UCNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/audio_word_fifo.sv
// Single-clock word FIFO with push/pop/flush, occupancy and registered read data.
// Latency: pop presents rd_dat on the next edge; push shows in count on the next edge.
// Backpressure: push refused while full, pop ignored while empty, flush overrides both.
module audio_word_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int W          = 32
) (
  input  logic                  in_clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [W-1:0]          wr_dat,
  input  logic                  pop,
  input  logic                  flush,
  output logic [W-1:0]          rd_dat,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int FW = DEPTH_LOG2 + 1;
  localparam logic [FW-1:0] DEPTH_V = FW'(2 ** DEPTH_LOG2);

  logic [W-1:0]            mem [2 ** DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic                    push_ok;
  logic                    pop_ok;

  assign full    = (count == DEPTH_V);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge in_clk) begin
    if (push_ok) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_dat <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      // rd_dat only moves on a real pop so the sender sees a stable word between pops
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_dat <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/audio_out_feeder.sv
// Feeds DMA stereo words to the I2S sender: prime/run/drain sequencing, underrun count (AUDIO_FEEDER_UNDERRUN_CNT_EN).
// Latency: request edge at N gives out_valid/out_data or underrun at N+2; start/end pulses one cycle after the condition.
// Backpressure: wr_ready drops when the FIFO is full; dma_req asks for a burst only in PRIME/RUN when room allows.
module audio_out_feeder
  import audio_feeder_pkg::*;
#(
  parameter int DEPTH_LOG2  = 4,
  parameter int PRIME_LEVEL = 8,
  parameter int REQ_BURST   = 4
) (
  input  logic                  in_clk,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  input  logic [SAMPLE_W-1:0]   wr_data,
  output logic                  wr_ready,
  output logic                  dma_req,
  input  logic                  cmd_start,
  input  logic                  cmd_end,
  input  logic                  audio_req_tick,
  output logic                  out_valid,
  output logic [SAMPLE_W-1:0]   out_data,
  output logic                  audio_start,
  output logic                  audio_end,
  output logic                  underrun,
  output logic [UCNT_W-1:0]     underrun_cnt,
  output logic [DEPTH_LOG2:0]   fill,
  output logic                  busy
);

  localparam int FW = DEPTH_LOG2 + 1;
  localparam logic [FW-1:0] DEPTH_V = FW'(2 ** DEPTH_LOG2);
  localparam logic [FW-1:0] PRIME_V = FW'(PRIME_LEVEL);
  localparam logic [FW-1:0] BURST_V = FW'(REQ_BURST);

  feeder_state_t state_q;
  feeder_state_t state_nxt;

  logic tick_q;
  logic req_q;
  logic fifo_full;
  logic fifo_empty;
  logic flush;
  logic pop_en;
  logic room_ok;
  logic start_nxt;
  logic end_nxt;
  logic under_nxt;

  assign room_ok  = (DEPTH_V - fill) >= BURST_V;
  assign flush    = (state_q == ST_PRIME) && cmd_end;
  assign wr_ready = ~fifo_full;
  assign busy     = (state_q != ST_IDLE);

  audio_word_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .W          (SAMPLE_W)
  ) u_fifo (
    .in_clk  (in_clk),
    .reset_n (reset_n),
    .push    (wr_valid),
    .wr_dat  (wr_data),
    .pop     (pop_en),
    .flush   (flush),
    .rd_dat  (out_data),
    .count   (fill),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_start && !cmd_end) state_nxt = ST_PRIME;
      ST_PRIME: begin
        if (cmd_end)               state_nxt = ST_IDLE;
        else if (fill >= PRIME_V)  state_nxt = ST_RUN;
      end
      ST_RUN:   if (cmd_end) state_nxt = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // An empty FIFO in DRAIN means end-of-stream, not a starved sender, so no underrun there
  always_comb begin
    dma_req   = 1'b0;
    pop_en    = 1'b0;
    start_nxt = 1'b0;
    end_nxt   = 1'b0;
    under_nxt = 1'b0;
    case (state_q)
      ST_PRIME: begin
        dma_req   = room_ok;
        start_nxt = !cmd_end && (fill >= PRIME_V);
      end
      ST_RUN: begin
        dma_req   = room_ok;
        pop_en    = req_q;
        under_nxt = req_q && fifo_empty;
      end
      ST_DRAIN: begin
        pop_en  = req_q;
        end_nxt = fifo_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q      <= 1'b0;
      req_q       <= 1'b0;
      out_valid   <= 1'b0;
      audio_start <= 1'b0;
      audio_end   <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      tick_q      <= audio_req_tick;
      req_q       <= audio_req_tick & ~tick_q;
      out_valid   <= pop_en & ~fifo_empty;
      audio_start <= start_nxt;
      audio_end   <= end_nxt;
      underrun    <= under_nxt;
    end
  end

`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
  logic [UCNT_W-1:0] ucnt_q;

  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n)                        ucnt_q <= '0;
    else if (underrun && (ucnt_q != '1)) ucnt_q <= ucnt_q + 1'b1;
  end

  assign underrun_cnt = ucnt_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_audio_out_feeder.sv
// Bench for audio_out_feeder: directed scenarios plus random traffic against a queue-based reference model.
module tb_audio_out_feeder;

  localparam int DEPTH = 16;
  localparam int PRIME = 8;
  localparam int BURST = 4;

  logic        in_clk = 1'b0;
  logic        reset_n;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        dma_req;
  logic        cmd_start;
  logic        cmd_end;
  logic        audio_req_tick;
  logic        out_valid;
  logic [31:0] out_data;
  logic        audio_start;
  logic        audio_end;
  logic        underrun;
  logic [15:0] underrun_cnt;
  logic [4:0]  fill;
  logic        busy;

  always #5 in_clk = ~in_clk;

  audio_out_feeder #(
    .DEPTH_LOG2  (4),
    .PRIME_LEVEL (PRIME),
    .REQ_BURST   (BURST)
  ) dut (
    .in_clk         (in_clk),
    .reset_n        (reset_n),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .dma_req        (dma_req),
    .cmd_start      (cmd_start),
    .cmd_end        (cmd_end),
    .audio_req_tick (audio_req_tick),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .audio_start    (audio_start),
    .audio_end      (audio_end),
    .underrun       (underrun),
    .underrun_cnt   (underrun_cnt),
    .fill           (fill),
    .busy           (busy)
  );

  typedef enum int {M_IDLE, M_PRIME, M_RUN, M_DRAIN} mode_t;

  mode_t       m_mode;
  logic [31:0] m_q[$];
  bit          m_prev_tick;
  bit          m_req_d;
  bit          e_out_valid;
  bit          e_start;
  bit          e_end;
  bit          e_under;
  logic [31:0] e_out_data;
  logic [15:0] e_ucnt;

  int n_chk;
  int n_bad;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode      = M_IDLE;
    m_prev_tick = 1'b0;
    m_req_d     = 1'b0;
    e_out_valid = 1'b0;
    e_start     = 1'b0;
    e_end       = 1'b0;
    e_under     = 1'b0;
    e_out_data  = '0;
    e_ucnt      = '0;
  endtask

  // One clock edge of the playback rules, applied to the inputs present in the cycle just ended
  task automatic model_edge();
    int n;
    bit serving, popw, pushw, under, flush, start, endp;
    n = m_q.size();
`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
    if (e_under && e_ucnt != 16'hFFFF) e_ucnt = e_ucnt + 16'd1;
`endif
    serving = m_req_d && (m_mode == M_RUN || m_mode == M_DRAIN);
    popw    = serving && n > 0;
    under   = m_req_d && m_mode == M_RUN && n == 0;
    pushw   = wr_valid && n < DEPTH;
    flush   = m_mode == M_PRIME && cmd_end;
    start   = m_mode == M_PRIME && !cmd_end && n >= PRIME;
    endp    = m_mode == M_DRAIN && n == 0;
    e_out_valid = popw;
    if (popw) e_out_data = m_q.pop_front();
    if (flush) m_q.delete();
    else if (pushw) m_q.push_back(wr_data);
    e_under = under;
    e_start = start;
    e_end   = endp;
    case (m_mode)
      M_IDLE:  if (cmd_start && !cmd_end) m_mode = M_PRIME;
      M_PRIME: if (cmd_end) m_mode = M_IDLE; else if (n >= PRIME) m_mode = M_RUN;
      M_RUN:   if (cmd_end) m_mode = M_DRAIN;
      M_DRAIN: if (n == 0) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
    m_req_d     = audio_req_tick && !m_prev_tick;
    m_prev_tick = audio_req_tick;
  endtask

  task automatic check_all();
    bit e_dma;
    e_dma = (m_mode == M_PRIME || m_mode == M_RUN) && (DEPTH - m_q.size() >= BURST);
    chk_eq("fill",         32'(fill),         32'(m_q.size()));
    chk_eq("wr_ready",     32'(wr_ready),     32'(m_q.size() != DEPTH));
    chk_eq("dma_req",      32'(dma_req),      32'(e_dma));
    chk_eq("busy",         32'(busy),         32'(m_mode != M_IDLE));
    chk_eq("out_valid",    32'(out_valid),    32'(e_out_valid));
    chk_eq("out_data",     out_data,          e_out_data);
    chk_eq("audio_start",  32'(audio_start),  32'(e_start));
    chk_eq("audio_end",    32'(audio_end),    32'(e_end));
    chk_eq("underrun",     32'(underrun),     32'(e_under));
    chk_eq("underrun_cnt", 32'(underrun_cnt), 32'(e_ucnt));
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge
  task automatic drive(input bit wv, input logic [31:0] wd, input bit cs, input bit ce, input bit tk);
    wr_valid       = wv;
    wr_data        = wd;
    cmd_start      = cs;
    cmd_end        = ce;
    audio_req_tick = tk;
    @(posedge in_clk);
    model_edge();
    @(negedge in_clk);
    check_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] words[8];
    logic [31:0] w2[2];
    int ov_cnt, ov_at, un_cnt, end_cnt;
    logic [31:0] ov_dat;

    n_chk = 0;
    n_bad = 0;
    reset_n = 1'b1;
    wr_valid = 1'b0; wr_data = '0; cmd_start = 1'b0; cmd_end = 1'b0; audio_req_tick = 1'b0;
    model_reset();
    #2 reset_n = 1'b0;
    repeat (2) @(negedge in_clk);
    check_all();
    chk_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk_eq("rst_out_data", out_data, 32'h0);
    reset_n = 1'b1;
    repeat (2) drive(0, '0, 0, 0, 0);

    // Prime: 3 preloaded words, start, 5 more words
    words[0] = 32'hD9999991;
    for (int i = 1; i < 8; i++) words[i] = $urandom;
    for (int i = 0; i < 3; i++) drive(1, words[i], 0, 0, 0);
    drive(0, '0, 1, 0, 0);
    chk_eq("prime_busy", 32'(busy), 32'd1);
    chk_eq("prime_dma", 32'(dma_req), 32'd1);
    for (int i = 3; i < 8; i++) drive(1, words[i], 0, 0, 0);
    chk_eq("prime_fill", 32'(fill), 32'd8);
    chk_eq("prime_start_early", 32'(audio_start), 32'd0);
    drive(0, '0, 0, 0, 0);
    chk_eq("prime_start", 32'(audio_start), 32'd1);
    drive(0, '0, 0, 0, 0);
    chk_eq("prime_start_once", 32'(audio_start), 32'd0);

    // Pop: request held high for 10 cycles pops exactly once
    ov_cnt = 0; ov_at = -1; ov_dat = '0;
    for (int i = 0; i < 10; i++) begin
      drive(0, '0, 0, 0, 1);
      if (out_valid) begin ov_cnt++; ov_at = i; ov_dat = out_data; end
    end
    drive(0, '0, 0, 0, 0);
    chk_eq("pop_count", 32'(ov_cnt), 32'd1);
    chk_eq("pop_latency", 32'(ov_at), 32'd1);
    chk_eq("pop_data", ov_dat, 32'hD9999991);
    chk_eq("pop_fill", 32'(fill), 32'd7);

    // Underrun: empty the FIFO then issue 3 more requests
    for (int i = 0; i < 7; i++) begin
      drive(0, '0, 0, 0, 1);
      drive(0, '0, 0, 0, 0);
    end
    repeat (2) drive(0, '0, 0, 0, 0);
    chk_eq("empty_fill", 32'(fill), 32'd0);
    ov_cnt = 0; un_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      drive(0, '0, 0, 0, 1);
      if (out_valid) ov_cnt++;
      if (underrun) un_cnt++;
      repeat (2) begin
        drive(0, '0, 0, 0, 0);
        if (out_valid) ov_cnt++;
        if (underrun) un_cnt++;
      end
    end
    repeat (2) begin
      drive(0, '0, 0, 0, 0);
      if (underrun) un_cnt++;
    end
    chk_eq("under_pulses", 32'(un_cnt), 32'd3);
    chk_eq("under_no_valid", 32'(ov_cnt), 32'd0);
    chk_eq("under_data_hold", out_data, words[7]);
`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
    chk_eq("under_cnt", 32'(underrun_cnt), 32'd3);
`else
    chk_eq("under_cnt", 32'(underrun_cnt), 32'd0);
`endif

    // Drain: two words queued, end command, two requests
    w2[0] = $urandom; w2[1] = $urandom;
    drive(1, w2[0], 0, 0, 0);
    drive(1, w2[1], 0, 0, 0);
    drive(0, '0, 0, 1, 0);
    chk_eq("drain_dma", 32'(dma_req), 32'd0);
    chk_eq("drain_busy", 32'(busy), 32'd1);
    ov_cnt = 0; un_cnt = 0; end_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, '0, 0, 0, (i == 0 || i == 2));
      if (out_valid) ov_cnt++;
      if (underrun) un_cnt++;
      if (audio_end) end_cnt++;
    end
    chk_eq("drain_pops", 32'(ov_cnt), 32'd2);
    chk_eq("drain_last", out_data, w2[1]);
    chk_eq("drain_end", 32'(end_cnt), 32'd1);
    chk_eq("drain_no_under", 32'(un_cnt), 32'd0);
    chk_eq("drain_idle", 32'(busy), 32'd0);

    // Full: 16 words, refused write, then pop-with-refused-push and push-with-pop
    for (int i = 0; i < 16; i++) drive(1, $urandom, 0, 0, 0);
    chk_eq("full_fill", 32'(fill), 32'd16);
    chk_eq("full_wr_ready", 32'(wr_ready), 32'd0);
    drive(1, 32'hBAD0BAD0, 0, 0, 0);
    chk_eq("full_drop", 32'(fill), 32'd16);
    drive(0, '0, 1, 0, 0);
    repeat (3) drive(0, '0, 0, 0, 0);
    drive(0, '0, 0, 0, 1);
    drive(1, 32'hBAD1BAD1, 0, 0, 1);
    chk_eq("full_pop_push_refused", 32'(fill), 32'd15);
    drive(0, '0, 0, 0, 0);
    drive(0, '0, 0, 0, 1);
    drive(1, $urandom, 0, 0, 1);
    chk_eq("push_pop_same", 32'(fill), 32'd15);
    drive(0, '0, 0, 0, 0);

    // Random traffic through all states
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 99) < 30, $urandom, $urandom_range(0, 29) == 0,
            $urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0);

    // Reset in the middle of a stream
    drive(0, '0, 0, 1, 0);
    drive(0, '0, 1, 0, 0);
    for (int i = 0; i < 12; i++) drive(1, $urandom, 0, 0, i % 2 == 1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk_eq("mid_rst_end", 32'(audio_end), 32'd0);
    @(negedge in_clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) drive(i % 3 == 0, $urandom, i == 2, 0, i % 4 == 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/audio_out_feeder.md
# audio_out_feeder

Buffers 32-bit stereo sample words (16-bit left in [31:16], 16-bit right in [15:0]) written by the sound-out DMA and hands one word per sample request to the downstream I2S sender. Runs entirely in the `in_clk` domain, directly upstream of the I2S sender:

- Drives the sender's `in_valid`/`data`/`audio_start`/`audio_end`.
- Consumes the sender's `audio_req_tick`.
- Sequences stream start (prime), run, drain and stop.
- Counts underruns.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 words (16).
- `PRIME_LEVEL`, 8: fill level required before `audio_start` is issued.
- `REQ_BURST`, 4: free words required for `dma_req` to assert.
- `in_clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset; release is synchronous to `in_clk`.
- `wr_valid`  in  1  DMA word valid.
- `wr_data`  in  32  DMA word.
- `wr_ready`  out  1  FIFO can accept a word. Equals `fill != 2^DEPTH_LOG2`.
- `dma_req`  out  1  ask the DMA for more words.
- `cmd_start`  in  1  1-cycle pulse: begin playback.
- `cmd_end`  in  1  1-cycle pulse: finish playback after the FIFO drains.
- `audio_req_tick`  in  1  sample request level from the sender, already synchronous to `in_clk`.
- `out_valid`  out  1  1-cycle pulse to the sender's `in_valid`.
- `out_data`  out  32  to the sender's `data`; holds its value until the next pop.
- `audio_start`  out  1  1-cycle pulse to the sender.
- `audio_end`  out  1  1-cycle pulse to the sender.
- `underrun`  out  1  1-cycle pulse: a request found the FIFO empty.
- `underrun_cnt`  out  16  saturating underrun count.
- `fill`  out  DEPTH_LOG2+1  current FIFO occupancy.
- `busy`  out  1  state is not IDLE.

## Operation
- **States:** IDLE, PRIME, RUN, DRAIN.
- **IDLE:**
  - FIFO writes are accepted, so the DMA can preload.
  - `dma_req` is 0.
  - `cmd_start` moves to PRIME.
- **PRIME:**
  - `dma_req` = 1 while `2^DEPTH_LOG2 - fill >= REQ_BURST`.
  - When `fill >= PRIME_LEVEL`, pulse `audio_start` for one cycle and move to RUN.
  - `cmd_end` in PRIME flushes the FIFO (`fill` := 0) and returns to IDLE. No `audio_start` or `audio_end` is issued.
- **RUN:**
  - `dma_req` follows the same rule as in PRIME.
  - Each request pops one word. A request with the FIFO empty produces `underrun`, no `out_valid`, and `out_data` unchanged.
  - `cmd_end` moves to DRAIN.
- **DRAIN:**
  - `dma_req` is 0. Requests keep popping.
  - In the first cycle in DRAIN with `fill == 0`, pulse `audio_end`, return to IDLE, and raise no `underrun`.
- **Request detect:** a request is a rising edge of `audio_req_tick`, detected by a registered previous value. A level held high counts once.
- **Push/pop in the same cycle:** both take effect and `fill` is unchanged. A push while full is refused by `wr_ready` = 0, even if a pop happens in that cycle.
- **Commands:**
  - `cmd_start` outside IDLE is ignored.
  - `cmd_end` in IDLE or DRAIN is ignored.
  - If `cmd_start` and `cmd_end` arrive in the same cycle, `cmd_end` wins, so IDLE stays IDLE.
- **Counter:** `underrun_cnt` increments on each `underrun`, saturates at 0xFFFF, and clears only on reset.
- **Pointers:** read and write pointers are DEPTH_LOG2 bits and wrap modulo depth.

## Timing
- **Reset values:** state = IDLE, `fill` = 0, `wr_ready` = 1, all other outputs 0 (`out_data` = 0x00000000, `underrun_cnt` = 0).
- **Pop latency:** a request edge at cycle N is registered at N+1; `out_valid` and the new `out_data` are presented at N+2.
- **Underrun latency:** `underrun` appears at N+2, the same cycle position an `out_valid` would have.
- **Prime and drain:** `audio_start` is registered in the cycle after `fill` reaches `PRIME_LEVEL`. `audio_end` is likewise registered in the cycle after empty is seen in DRAIN.
- **Write:** a `wr_valid && wr_ready` cycle increments `fill` at the next edge.
- **Reset asserted mid-stream:** everything returns to reset values immediately. No `audio_end` is emitted.

## Configuration
- `AUDIO_FEEDER_UNDERRUN_CNT_EN`:
  - **Defined:** the 16-bit saturating counter is built.
  - **Undefined:** `underrun_cnt` is tied to 0 and no counter flops are built. The `underrun` pulse is still generated.

## Structure
- **Shared package `audio_feeder_pkg`:**
  - State encoding (IDLE = 0, PRIME = 1, RUN = 2, DRAIN = 3).
  - Sample word width 32.
  - Underrun counter width 16.
- **Sub-module `audio_word_fifo`:** synchronous single-clock FIFO with push/pop/flush, occupancy, full/empty and a registered read data output. The FSM, request edge detect and counter live in the `audio_out_feeder` top.

## Test plan
- **Reset:** assert `reset_n` = 0 -> `wr_ready` = 1, `fill` = 0, all other outputs 0.
- **Prime:** preload 3 words in IDLE, pulse `cmd_start`, write 5 more -> `dma_req` = 1 in PRIME; `audio_start` pulses one cycle after `fill` = 8.
- **Pop:** in RUN with `fill` = 8, raise `audio_req_tick` at cycle N and hold it high for 10 cycles -> exactly one `out_valid` at N+2 carrying the first-written word (e.g. 0xD9999991); `fill` = 7.
- **Underrun:** FIFO empty in RUN, 3 request edges -> 3 `underrun` pulses, no `out_valid`, `underrun_cnt` = 3 (0 without `AUDIO_FEEDER_UNDERRUN_CNT_EN`), `out_data` unchanged.
- **Drain:** 2 words queued, pulse `cmd_end` -> `dma_req` = 0; 2 requests pop 2 words; `audio_end` pulses after empty; state IDLE; `underrun` never asserted.
- **Full/simultaneous:** `fill` = 16 -> `wr_ready` = 0 and a write is dropped; at `fill` = 15, a push and a request pop in the same cycle leave `fill` = 15.
